// File: rtl/store_drain_pkg.sv
// Shared types and constants for the store-drain controller and its strobe generator.
`include "defines.sv"

package store_drain_pkg;

    localparam int unsigned STRB_W = 4;
    localparam int unsigned SIZE_W = `SIZE_WRITE_WIDTH;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = `BYTE_SIZE;
    localparam logic [SIZE_W-1:0] SIZE_WORD = `FULL_WORD_SIZE;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        MISS  = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } drain_state_t;

endpackage

// File: rtl/store_drain_ctrl_if.sv
// Store-buffer head, cache write port and line-fill handshake seen by the drain controller.
interface store_drain_ctrl_if
    import store_drain_pkg::*;
#(
    parameter int unsigned WORD_SIZE     = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH   = 16
);

    logic                     sb_valid;
    logic [ADDRESS_WIDTH-1:0] sb_addr;
    logic [WORD_SIZE-1:0]     sb_value;
    logic [SIZE_W-1:0]        sb_size;
    logic                     store_success;
    logic                     load_active;
    logic                     dc_wr_req;
    logic [ADDRESS_WIDTH-1:0] dc_wr_addr;
    logic [WORD_SIZE-1:0]     dc_wr_data;
    logic [STRB_W-1:0]        dc_wr_strb;
    logic                     dc_wr_hit;
    logic                     dc_wr_miss;
    logic                     mem_fill_req;
    logic                     mem_fill_done;
    logic                     align_error;
    logic                     busy;
    logic [COUNT_WIDTH-1:0]   drained_count;

    modport master (
        input  sb_valid, sb_addr, sb_value, sb_size, load_active,
               dc_wr_hit, dc_wr_miss, mem_fill_done,
        output store_success, dc_wr_req, dc_wr_addr, dc_wr_data, dc_wr_strb,
               mem_fill_req, align_error, busy, drained_count
    );

    modport slave (
        output sb_valid, sb_addr, sb_value, sb_size, load_active,
               dc_wr_hit, dc_wr_miss, mem_fill_done,
        input  store_success, dc_wr_req, dc_wr_addr, dc_wr_data, dc_wr_strb,
               mem_fill_req, align_error, busy, drained_count
    );

endinterface

// File: rtl/defines.sv
// Store op size encodings shared by the store buffer, drain controller and load bypass.
`ifndef STORE_DEFINES_SV
`define STORE_DEFINES_SV

`define SIZE_WRITE_WIDTH 2
`define BYTE_SIZE        2'b01
`define FULL_WORD_SIZE   2'b10

`endif

// File: rtl/store_strobe_gen.sv
// Byte-lane enables and lane-replicated write data for a store of a given size and offset.
module store_strobe_gen
    import store_drain_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic [SIZE_W-1:0]    size_i,
    input  logic [1:0]           addr_lo_i,
    input  logic [WORD_SIZE-1:0] value_i,
    output logic [STRB_W-1:0]    strb_o,
    output logic [WORD_SIZE-1:0] data_o
);

    // Unknown size encodings still pass data through but enable no lanes.
    always_comb begin
        strb_o = '0;
        data_o = value_i;
        case (size_i)
            SIZE_BYTE: begin
                strb_o = STRB_W'(1) << addr_lo_i;
                data_o = {(WORD_SIZE/8){value_i[7:0]}};
            end
            SIZE_WORD: strb_o = '1;
            default:   strb_o = '0;
        endcase
    end

endmodule

// File: rtl/store_drain_ctrl.sv
// Drains the store buffer head into the data cache one store at a time, filling lines on a miss.
module store_drain_ctrl
    import store_drain_pkg::*;
#(
    parameter int unsigned WORD_SIZE     = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH   = 16
) (
    input  logic               clk,
    input  logic               rst,
    store_drain_ctrl_if.master bus
);

    drain_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]     value_q, value_d;
    logic [SIZE_W-1:0]        size_q, size_d;
    logic                     err_q, err_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;

    logic wr_req, fill_req, success, align_err, misaligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            value_q <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            value_q <= value_d;
            size_q  <= size_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign misaligned = (bus.sb_size == SIZE_WORD) && (bus.sb_addr[1:0] != 2'b00);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        value_d   = value_q;
        size_d    = size_q;
        err_d     = err_q;
        count_d   = count_q;
        wr_req    = 1'b0;
        fill_req  = 1'b0;
        success   = 1'b0;
        align_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sb_valid) begin
                    addr_d  = bus.sb_addr;
                    value_d = bus.sb_value;
                    size_d  = bus.sb_size;
                    err_d   = misaligned;
                    state_d = misaligned ? DONE : WRITE;
                end
            end
            WRITE: begin
                // Loads own the port; a hit wins over a simultaneous miss.
                if (!bus.load_active) begin
                    wr_req = 1'b1;
                    if (bus.dc_wr_hit)       state_d = DONE;
                    else if (bus.dc_wr_miss) state_d = MISS;
                end
            end
            MISS: begin
                fill_req = 1'b1;
                if (bus.mem_fill_done) state_d = WRITE;
            end
            DONE: begin
                success   = 1'b1;
                align_err = err_q;
                count_d   = count_q + COUNT_WIDTH'(1);
                state_d   = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    store_strobe_gen #(
        .WORD_SIZE (WORD_SIZE)
    ) u_strobe_gen (
        .size_i    (size_q),
        .addr_lo_i (addr_q[1:0]),
        .value_i   (value_q),
        .strb_o    (bus.dc_wr_strb),
        .data_o    (bus.dc_wr_data)
    );

    assign bus.dc_wr_req     = wr_req;
    assign bus.dc_wr_addr    = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
    assign bus.mem_fill_req  = fill_req;
    assign bus.store_success = success;
    assign bus.align_error   = align_err;
    assign bus.busy          = (state_q != IDLE);
    assign bus.drained_count = count_q;

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Directed bench for store_drain_ctrl: hit, byte lanes, miss/fill, load priority, misalignment, reset.
module tb_store_drain_ctrl;
    import store_drain_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   exp_count;

    store_drain_ctrl_if #(.WORD_SIZE(32), .ADDRESS_WIDTH(32), .COUNT_WIDTH(16)) bus ();

    store_drain_ctrl #(
        .WORD_SIZE     (32),
        .ADDRESS_WIDTH (32),
        .COUNT_WIDTH   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] addr, input logic [31:0] val, input logic [SIZE_W-1:0] size);
        bus.sb_valid = 1'b1;
        bus.sb_addr  = addr;
        bus.sb_value = val;
        bus.sb_size  = size;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   32'(bus.dc_wr_req), 0);
        check({tag, "_fill"},  32'(bus.mem_fill_req), 0);
        check({tag, "_succ"},  32'(bus.store_success), 0);
        check({tag, "_align"}, 32'(bus.align_error), 0);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_addr"},  bus.dc_wr_addr, 0);
        check({tag, "_data"},  bus.dc_wr_data, 0);
        check({tag, "_strb"},  32'(bus.dc_wr_strb), 0);
        check({tag, "_cnt"},   32'(bus.drained_count), 0);
    endtask

    initial begin
        logic [31:0] byte_addr [2];
        logic [31:0] byte_strb [2];
        byte_addr[0] = 32'h203; byte_strb[0] = 32'h8;
        byte_addr[1] = 32'h201; byte_strb[1] = 32'h2;
        n_checks  = 0;
        n_fail    = 0;
        exp_count = 0;
        rst = 1'b0;
        bus.sb_valid = 1'b0; bus.sb_addr = '0; bus.sb_value = '0; bus.sb_size = '0;
        bus.load_active = 1'b0; bus.dc_wr_hit = 1'b0; bus.dc_wr_miss = 1'b0;
        bus.mem_fill_done = 1'b0;
        #2;
        check_all_zero("reset");
        tick(); tick();
        rst = 1'b1;

        // Word hit: sample cycle 0, request cycle 1, success cycle 2, GAP cycle 3.
        present(32'h100, 32'hDEADBEEF, SIZE_WORD);
        #1 check("hit_idle_busy", 32'(bus.busy), 0);
        tick(); bus.sb_valid = 1'b0; bus.dc_wr_hit = 1'b1;
        #1 check("hit_req", 32'(bus.dc_wr_req), 1);
        check("hit_strb", 32'(bus.dc_wr_strb), 32'hF);
        check("hit_addr", bus.dc_wr_addr, 32'h100);
        check("hit_data", bus.dc_wr_data, 32'hDEADBEEF);
        tick(); bus.dc_wr_hit = 1'b0;
        #1 check("hit_succ", 32'(bus.store_success), 1);
        check("hit_align", 32'(bus.align_error), 0);
        exp_count++;
        tick();
        #1 check("hit_gap_succ", 32'(bus.store_success), 0);
        check("hit_gap_busy", 32'(bus.busy), 1);
        check("hit_cnt", 32'(bus.drained_count), 32'(exp_count));
        tick();
        #1 check("hit_idle_again", 32'(bus.busy), 0);

        // Byte stores land in the addressed lane with replicated data.
        for (int i = 0; i < 2; i++) begin
            present(byte_addr[i], 32'h000000A5, SIZE_BYTE);
            tick(); bus.sb_valid = 1'b0; bus.dc_wr_hit = 1'b1;
            #1 check("byte_req", 32'(bus.dc_wr_req), 1);
            check("byte_addr", bus.dc_wr_addr, 32'h200);
            check("byte_data", bus.dc_wr_data, 32'hA5A5A5A5);
            check("byte_strb", 32'(bus.dc_wr_strb), byte_strb[i]);
            tick(); bus.dc_wr_hit = 1'b0;
            #1 check("byte_succ", 32'(bus.store_success), 1);
            exp_count++;
            tick(); tick();
        end
        check("byte_cnt", 32'(bus.drained_count), 32'(exp_count));

        // Stray fill completion while idle is ignored.
        bus.mem_fill_done = 1'b1;
        #1 check("stray_fill_req", 32'(bus.mem_fill_req), 0);
        tick(); bus.mem_fill_done = 1'b0;
        #1 check("stray_fill_busy", 32'(bus.busy), 0);

        // Miss, fill returns 5 cycles after the miss, retry hits, success in cycle 9.
        present(32'h300, 32'h12345678, SIZE_WORD);
        tick(); bus.sb_valid = 1'b0; bus.dc_wr_miss = 1'b1;
        #1 check("miss_req", 32'(bus.dc_wr_req), 1);
        check("miss_fill_pre", 32'(bus.mem_fill_req), 0);
        tick(); bus.dc_wr_miss = 1'b0;
        for (int c = 2; c <= 7; c++) begin
            if (c == 7) bus.mem_fill_done = 1'b1;
            #1 check("miss_fill_req", 32'(bus.mem_fill_req), 1);
            check("miss_no_wr", 32'(bus.dc_wr_req), 0);
            tick(); bus.mem_fill_done = 1'b0;
        end
        bus.dc_wr_hit = 1'b1;
        #1 check("retry_req", 32'(bus.dc_wr_req), 1);
        check("retry_fill", 32'(bus.mem_fill_req), 0);
        check("retry_addr", bus.dc_wr_addr, 32'h300);
        tick(); bus.dc_wr_hit = 1'b0;
        #1 check("miss_succ_c9", 32'(bus.store_success), 1);
        exp_count++;
        tick(); tick();

        // Load holds the port for 3 cycles from WRITE entry; success moves from cycle 2 to 5.
        present(32'h500, 32'h0BADF00D, SIZE_WORD);
        tick(); bus.sb_valid = 1'b0; bus.load_active = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1 check("load_no_req", 32'(bus.dc_wr_req), 0);
            check("load_no_succ", 32'(bus.store_success), 0);
            tick();
        end
        bus.load_active = 1'b0; bus.dc_wr_hit = 1'b1;
        #1 check("load_req", 32'(bus.dc_wr_req), 1);
        tick(); bus.dc_wr_hit = 1'b0;
        #1 check("load_succ_c5", 32'(bus.store_success), 1);
        exp_count++;
        tick(); tick();

        // Misaligned word is dropped: error and retire together in cycle 1.
        present(32'h102, 32'h11223344, SIZE_WORD);
        tick(); bus.sb_valid = 1'b0;
        #1 check("mis_no_req", 32'(bus.dc_wr_req), 0);
        check("mis_succ", 32'(bus.store_success), 1);
        check("mis_align", 32'(bus.align_error), 1);
        exp_count++;
        tick();
        #1 check("mis_gap_align", 32'(bus.align_error), 0);
        check("mis_cnt", 32'(bus.drained_count), 32'(exp_count));
        tick();

        // Reset in MISS aborts; the held entry drains after release.
        present(32'h400, 32'hCAFEF00D, SIZE_WORD);
        tick(); bus.dc_wr_miss = 1'b1;
        #1 check("rst_miss_req", 32'(bus.dc_wr_req), 1);
        tick(); bus.dc_wr_miss = 1'b0;
        #1 check("rst_in_miss", 32'(bus.mem_fill_req), 1);
        #2 rst = 1'b0;
        #1 check_all_zero("rst_async");
        tick(); tick();
        check("rst_hold_succ", 32'(bus.store_success), 0);
        check("rst_hold_busy", 32'(bus.busy), 0);
        rst = 1'b1;
        tick(); bus.sb_valid = 1'b0; bus.dc_wr_hit = 1'b1;
        #1 check("redrain_req", 32'(bus.dc_wr_req), 1);
        check("redrain_addr", bus.dc_wr_addr, 32'h400);
        check("redrain_data", bus.dc_wr_data, 32'hCAFEF00D);
        tick(); bus.dc_wr_hit = 1'b0;
        #1 check("redrain_succ", 32'(bus.store_success), 1);
        tick();
        #1 check("redrain_cnt", 32'(bus.drained_count), 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
